regfile_wb_arbiter: RTL and testbench
=====================================

REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

Interface
REQ-001 Parameter: DATA_W, 32, write-data width.
REQ-002 Parameter: ADDR_W, 5, register-address width; 2**ADDR_W registers.
REQ-003 clk  in  1  single clock; all state on posedge.
REQ-004 rst_n  in  1  reset, asynchronous, active-low.
REQ-005 alu_req  in  1  ALU writeback request; held with alu_addr/alu_data until granted.
REQ-006 alu_addr  in  ADDR_W  ALU destination register.
REQ-007 alu_data  in  DATA_W  ALU result.
REQ-008 alu_gnt  out  1  combinational grant; alu_req & alu_gnt = transfer.
REQ-009 mem_req, mem_addr, mem_data, mem_gnt: SHALL match the ALU set, for memory-load writeback.
REQ-010 wr_en  out  1  registered write strobe to register-file write port.
REQ-011 wr_addr  out  ADDR_W  registered write address.
REQ-012 wr_data  out  DATA_W  registered write data.
REQ-013 busy_set  in  1  issue stage marks busy_addr as pending-write.
REQ-014 busy_addr  in  ADDR_W  register being marked pending.
REQ-015 rs_addr, rt_addr  in  ADDR_W  operand addresses being queried.
REQ-016 rs_busy, rt_busy  out  1  combinational pending flag of rs_addr/rt_addr.
REQ-017 stall_cnt  out  16  saturating count of denied-request cycles.

Function
REQ-018 At most one grant per cycle; single requester SHALL be granted in the same cycle.
REQ-019 Both requesting: grant the requester not granted in the most recent two-way contention (round-robin state last_win); after reset, MEM wins first contention.
REQ-020 last_win SHALL update only on cycles where both requested; uncontested grants leave it unchanged.
REQ-021 Transfer in cycle N -> wr_en=1, wr_addr/wr_data = granted values in cycle N+1; no transfer -> wr_en=0 in N+1, wr_addr/wr_data hold.
REQ-022 Transfer with address 0 SHALL be granted (consumed) but produce wr_en=0 in N+1; register 0 never written.
REQ-023 Scoreboard: busy[2**ADDR_W-1:0]; busy[0] constantly 0.
REQ-024 busy_set=1, busy_addr!=0 -> busy[busy_addr] set at clock edge.
REQ-025 wr_en=1 -> busy[wr_addr] cleared at that cycle's closing edge (same edge the register file writes).
REQ-026 Set and clear of the same address on the same edge: set wins (newer producer).
REQ-027 rs_busy=busy[rs_addr], rt_busy=busy[rt_addr]; no bypass of the in-flight write.
REQ-028 stall_cnt increments by 1 on each cycle where a req is high without its grant; saturates at 16'hFFFF; never wraps.
REQ-029 A requester dropping req without grant is legal; no state change results.
REQ-030 Grant logic SHALL depend only on req inputs and last_win, never on addr/data.

Reset
REQ-031 rst_n low (asynchronous): wr_en=0, wr_addr=0, wr_data=0, busy=all 0, stall_cnt=0, last_win=ALU (so MEM wins next contention).
REQ-032 During reset alu_gnt=mem_gnt=0; transfers in flight at reset assertion are discarded, not written.
REQ-033 First transfer possible in the first cycle after rst_n deasserts.

Structure
REQ-034 Shared package holds ADDR_W/DATA_W defaults and requester-ID encoding (REQ_ALU=0, REQ_MEM=1).
REQ-035 One sub-module, wb_scoreboard (busy vector, set/clear, two query ports); arbitration and output register stay in the top.

Verification
REQ-036 ALU-only: alu_req, addr=3, data=32'h0000_00AA in cycle 1 -> alu_gnt=1 cycle 1; wr_en=1, wr_addr=3, wr_data=32'hAA cycle 2.
REQ-037 Contention: both req held 4 cycles after reset -> grants MEM, ALU, MEM, ALU; stall_cnt=4 at end (one denied per cycle while both held, loser keeps requesting).
REQ-038 Address 0: mem_req addr=0 data=32'hFFFF_FFFF -> mem_gnt=1, next cycle wr_en=0; busy[0] remains 0.
REQ-039 Scoreboard: busy_set addr=7 -> rs_addr=7 gives rs_busy=1 next cycle; ALU write to 7 -> rs_busy=0 in the cycle after wr_en; simultaneous busy_set 7 with wr_en addr 7 -> rs_busy stays 1.
REQ-040 Reset mid-operation: assert rst_n low with both requests pending and busy[5]=1 -> wr_en, stall_cnt, busy all 0 immediately, grants 0; after release, MEM wins first contention.
REQ-041 Saturation: force 65540 denied cycles -> stall_cnt holds 16'hFFFF.

Source files
------------

// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared definitions for the register-file writeback arbiter: default widths
// and the requester-ID encoding used for the round-robin state.
package regfile_wb_arbiter_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 5;
    localparam int STALL_W    = 16;

    typedef enum logic {
        REQ_ALU = 1'b0,
        REQ_MEM = 1'b1
    } req_id_e;

endpackage

// File: rtl/wb_scoreboard.sv
// Pending-write scoreboard: one busy bit per register, set by issue and
// cleared by writeback, with two combinational query ports.
module wb_scoreboard
    import regfile_wb_arbiter_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              set_en,
    input  logic [ADDR_W-1:0] set_addr,
    input  logic              clr_en,
    input  logic [ADDR_W-1:0] clr_addr,
    input  logic [ADDR_W-1:0] rs_addr,
    input  logic [ADDR_W-1:0] rt_addr,
    output logic              rs_busy,
    output logic              rt_busy
);

    localparam int NREG = 1 << ADDR_W;

    logic [NREG-1:0] busy_q;
    logic [NREG-1:0] busy_d;

    // Clear is applied before set so a new producer issued on the same edge
    // as the older write retiring keeps the register marked pending.
    always_comb begin
        busy_d = busy_q;
        if (clr_en) begin
            busy_d[clr_addr] = 1'b0;
        end
        if (set_en && (set_addr != '0)) begin
            busy_d[set_addr] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign rs_busy = busy_q[rs_addr];
    assign rt_busy = busy_q[rt_addr];

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Two-requester (ALU / memory) writeback arbiter with a registered
// register-file write port, pending-write scoreboard and stall counter.
module regfile_wb_arbiter
    import regfile_wb_arbiter_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              alu_req,
    input  logic [ADDR_W-1:0] alu_addr,
    input  logic [DATA_W-1:0] alu_data,
    output logic              alu_gnt,
    input  logic              mem_req,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_data,
    output logic              mem_gnt,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    input  logic              busy_set,
    input  logic [ADDR_W-1:0] busy_addr,
    input  logic [ADDR_W-1:0] rs_addr,
    input  logic [ADDR_W-1:0] rt_addr,
    output logic              rs_busy,
    output logic              rt_busy,
    output logic [15:0]       stall_cnt
);

    function automatic logic [STALL_W-1:0] sat_inc(input logic [STALL_W-1:0] v);
        if (v == {STALL_W{1'b1}}) begin
            return v;
        end
        return v + {{(STALL_W-1){1'b0}}, 1'b1};
    endfunction

    req_id_e             last_win_q, last_win_d;
    logic                wr_en_q, wr_en_d;
    logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
    logic [DATA_W-1:0]   wr_data_q, wr_data_d;
    logic [STALL_W-1:0]  stall_cnt_q, stall_cnt_d;
    logic                alu_gnt_c, mem_gnt_c;
    logic [ADDR_W-1:0]   sel_addr;
    logic [DATA_W-1:0]   sel_data;
    logic                denied;

    // Grants look only at the requests and round-robin state; held off in reset.
    always_comb begin
        alu_gnt_c = 1'b0;
        mem_gnt_c = 1'b0;
        if (rst_n) begin
            if (alu_req && mem_req) begin
                if (last_win_q == REQ_ALU) begin
                    mem_gnt_c = 1'b1;
                end else begin
                    alu_gnt_c = 1'b1;
                end
            end else begin
                alu_gnt_c = alu_req;
                mem_gnt_c = mem_req;
            end
        end
    end

    always_comb begin
        sel_addr    = mem_gnt_c ? mem_addr : alu_addr;
        sel_data    = mem_gnt_c ? mem_data : alu_data;
        wr_en_d     = (alu_gnt_c || mem_gnt_c) && (sel_addr != '0);
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;
        last_win_d  = last_win_q;
        denied      = (alu_req && !alu_gnt_c) || (mem_req && !mem_gnt_c);
        stall_cnt_d = denied ? sat_inc(stall_cnt_q) : stall_cnt_q;
        if (wr_en_d) begin
            wr_addr_d = sel_addr;
            wr_data_d = sel_data;
        end
        if (alu_req && mem_req) begin
            last_win_d = mem_gnt_c ? REQ_MEM : REQ_ALU;
        end
    end

    // Reset leaves last_win at ALU so memory takes the first contention.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_win_q  <= REQ_ALU;
            wr_en_q     <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            stall_cnt_q <= '0;
        end else begin
            last_win_q  <= last_win_d;
            wr_en_q     <= wr_en_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    wb_scoreboard #(
        .ADDR_W (ADDR_W)
    ) u_scoreboard (
        .clk      (clk),
        .rst_n    (rst_n),
        .set_en   (busy_set),
        .set_addr (busy_addr),
        .clr_en   (wr_en_q),
        .clr_addr (wr_addr_q),
        .rs_addr  (rs_addr),
        .rt_addr  (rt_addr),
        .rs_busy  (rs_busy),
        .rt_busy  (rt_busy)
    );

    assign alu_gnt   = alu_gnt_c;
    assign mem_gnt   = mem_gnt_c;
    assign wr_en     = wr_en_q;
    assign wr_addr   = wr_addr_q;
    assign wr_data   = wr_data_q;
    assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: table of per-cycle vectors plus
// hand-written reset-in-flight and stall-saturation sequences.
module tb_regfile_wb_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        alu_req, mem_req, busy_set;
    logic [4:0]  alu_addr, mem_addr, busy_addr, rs_addr, rt_addr;
    logic [31:0] alu_data, mem_data;
    logic        alu_gnt, mem_gnt, wr_en, rs_busy, rt_busy;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic [15:0] stall_cnt;

    int n_total = 0;
    int n_pass  = 0;

    always #5 clk = ~clk;

    regfile_wb_arbiter dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .alu_req   (alu_req),
        .alu_addr  (alu_addr),
        .alu_data  (alu_data),
        .alu_gnt   (alu_gnt),
        .mem_req   (mem_req),
        .mem_addr  (mem_addr),
        .mem_data  (mem_data),
        .mem_gnt   (mem_gnt),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .busy_set  (busy_set),
        .busy_addr (busy_addr),
        .rs_addr   (rs_addr),
        .rt_addr   (rt_addr),
        .rs_busy   (rs_busy),
        .rt_busy   (rt_busy),
        .stall_cnt (stall_cnt)
    );

    // Inputs for one cycle; grants/busy expected before the edge, write port
    // and stall count expected after it.
    typedef struct {
        logic        ar; logic [4:0] aa; logic [31:0] ad;
        logic        mr; logic [4:0] ma; logic [31:0] md;
        logic        bs; logic [4:0] ba; logic [4:0] rs; logic [4:0] rt;
        logic        e_ag; logic e_mg; logic e_rs; logic e_rt;
        logic        e_we; logic [4:0] e_wa; logic [31:0] e_wd; logic [15:0] e_st;
    } vec_t;

    function automatic vec_t mk(
        logic ar, logic [4:0] aa, logic [31:0] ad,
        logic mr, logic [4:0] ma, logic [31:0] md,
        logic bs, logic [4:0] ba, logic [4:0] rs, logic [4:0] rt,
        logic e_ag, logic e_mg, logic e_rs, logic e_rt,
        logic e_we, logic [4:0] e_wa, logic [31:0] e_wd, logic [15:0] e_st);
        vec_t v;
        v.ar = ar; v.aa = aa; v.ad = ad; v.mr = mr; v.ma = ma; v.md = md;
        v.bs = bs; v.ba = ba; v.rs = rs; v.rt = rt;
        v.e_ag = e_ag; v.e_mg = e_mg; v.e_rs = e_rs; v.e_rt = e_rt;
        v.e_we = e_we; v.e_wa = e_wa; v.e_wd = e_wd; v.e_st = e_st;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic drive(input logic ar, input logic [4:0] aa, input logic [31:0] ad,
                         input logic mr, input logic [4:0] ma, input logic [31:0] md,
                         input logic bs, input logic [4:0] ba,
                         input logic [4:0] rs, input logic [4:0] rt);
        alu_req = ar; alu_addr = aa; alu_data = ad;
        mem_req = mr; mem_addr = ma; mem_data = md;
        busy_set = bs; busy_addr = ba; rs_addr = rs; rt_addr = rt;
    endtask

    vec_t vecs[21];

    initial begin
        // inputs:  ar aa ad          mr ma md            bs ba  rs rt | ag mg rs rt | we wa wd        st
        vecs[0]  = mk(1, 3, 32'hAA,   0, 0, 0,            0, 0,  3, 7,   1, 0, 0, 0,   1, 3, 32'hAA,   0);
        vecs[1]  = mk(0, 0, 0,        0, 0, 0,            1, 7,  7, 7,   0, 0, 0, 0,   0, 3, 32'hAA,   0);
        vecs[2]  = mk(0, 0, 0,        0, 0, 0,            0, 0,  7, 3,   0, 0, 1, 0,   0, 3, 32'hAA,   0);
        vecs[3]  = mk(1, 7, 32'h1234, 0, 0, 0,            0, 0,  7, 3,   1, 0, 1, 0,   1, 7, 32'h1234, 0);
        vecs[4]  = mk(0, 0, 0,        0, 0, 0,            0, 0,  7, 3,   0, 0, 1, 0,   0, 7, 32'h1234, 0);
        vecs[5]  = mk(0, 0, 0,        0, 0, 0,            0, 0,  7, 7,   0, 0, 0, 0,   0, 7, 32'h1234, 0);
        vecs[6]  = mk(0, 0, 0,        1, 0, 32'hFFFFFFFF, 0, 0,  0, 0,   0, 1, 0, 0,   0, 7, 32'h1234, 0);
        vecs[7]  = mk(0, 0, 0,        0, 0, 0,            1, 0,  0, 0,   0, 0, 0, 0,   0, 7, 32'h1234, 0);
        vecs[8]  = mk(0, 0, 0,        0, 0, 0,            0, 0,  0, 0,   0, 0, 0, 0,   0, 7, 32'h1234, 0);
        vecs[9]  = mk(1, 7, 32'h55,   0, 0, 0,            1, 7,  7, 3,   1, 0, 0, 0,   1, 7, 32'h55,   0);
        vecs[10] = mk(0, 0, 0,        0, 0, 0,            1, 7,  7, 7,   0, 0, 1, 1,   0, 7, 32'h55,   0);
        vecs[11] = mk(0, 0, 0,        0, 0, 0,            0, 0,  7, 7,   0, 0, 1, 1,   0, 7, 32'h55,   0);
        vecs[12] = mk(1, 1, 32'h11,   1, 2, 32'h22,       0, 0,  1, 2,   0, 1, 0, 0,   1, 2, 32'h22,   1);
        vecs[13] = mk(1, 1, 32'h11,   1, 2, 32'h22,       0, 0,  1, 2,   1, 0, 0, 0,   1, 1, 32'h11,   2);
        vecs[14] = mk(1, 1, 32'h11,   1, 2, 32'h22,       0, 0,  1, 2,   0, 1, 0, 0,   1, 2, 32'h22,   3);
        vecs[15] = mk(1, 1, 32'h11,   1, 2, 32'h22,       0, 0,  1, 2,   1, 0, 0, 0,   1, 1, 32'h11,   4);
        vecs[16] = mk(0, 0, 0,        1, 2, 32'h33,       0, 0,  1, 2,   0, 1, 0, 0,   1, 2, 32'h33,   4);
        vecs[17] = mk(1, 1, 32'h11,   1, 2, 32'h44,       0, 0,  1, 2,   0, 1, 0, 0,   1, 2, 32'h44,   5);
        vecs[18] = mk(1, 9, 32'h99,   0, 0, 0,            1, 9,  9, 0,   1, 0, 0, 0,   1, 9, 32'h99,   5);
        vecs[19] = mk(0, 0, 0,        0, 0, 0,            0, 0,  9, 0,   0, 0, 1, 0,   0, 9, 32'h99,   5);
        vecs[20] = mk(0, 0, 0,        0, 0, 0,            0, 0,  9, 0,   0, 0, 0, 0,   0, 9, 32'h99,   5);

        // Reset with both requesting: grants must stay low.
        rst_n = 1'b0;
        drive(1, 4, 32'hDEAD, 1, 6, 32'hBEEF, 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        #1;
        chk("rst_alu_gnt", alu_gnt, 0);
        chk("rst_mem_gnt", mem_gnt, 0);
        chk("rst_wr_en", wr_en, 0);
        chk("rst_wr_addr", wr_addr, 0);
        chk("rst_wr_data", wr_data, 0);
        chk("rst_stall", stall_cnt, 0);
        rst_n = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        for (int i = 0; i < 21; i++) begin
            drive(vecs[i].ar, vecs[i].aa, vecs[i].ad, vecs[i].mr, vecs[i].ma, vecs[i].md,
                  vecs[i].bs, vecs[i].ba, vecs[i].rs, vecs[i].rt);
            @(negedge clk);
            chk($sformatf("v%0d_alu_gnt", i), alu_gnt, vecs[i].e_ag);
            chk($sformatf("v%0d_mem_gnt", i), mem_gnt, vecs[i].e_mg);
            chk($sformatf("v%0d_rs_busy", i), rs_busy, vecs[i].e_rs);
            chk($sformatf("v%0d_rt_busy", i), rt_busy, vecs[i].e_rt);
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_wr_en", i), wr_en, vecs[i].e_we);
            chk($sformatf("v%0d_wr_addr", i), wr_addr, vecs[i].e_wa);
            chk($sformatf("v%0d_wr_data", i), wr_data, vecs[i].e_wd);
            chk($sformatf("v%0d_stall", i), stall_cnt, vecs[i].e_st);
        end

        // Asynchronous reset with a write in flight and register 5 pending.
        drive(1, 4, 32'h4444, 1, 6, 32'h6666, 1, 5, 5, 0);
        @(posedge clk);
        #1;
        busy_set = 1'b0;
        chk("pre_rst_wr_en", wr_en, 1);
        chk("pre_rst_busy5", rs_busy, 1);
        chk("pre_rst_stall", stall_cnt, 6);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_wr_en", wr_en, 0);
        chk("async_rst_stall", stall_cnt, 0);
        chk("async_rst_busy5", rs_busy, 0);
        chk("async_rst_alu_gnt", alu_gnt, 0);
        chk("async_rst_mem_gnt", mem_gnt, 0);
        @(posedge clk);
        #1;
        chk("in_rst_wr_en", wr_en, 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_mem_gnt", mem_gnt, 1);
        chk("post_rst_alu_gnt", alu_gnt, 0);
        @(posedge clk);
        #1;
        chk("post_rst_wr_addr", wr_addr, 6);
        chk("post_rst_wr_data", wr_data, 32'h6666);
        chk("post_rst_stall", stall_cnt, 1);

        // Hold contention long enough to saturate the stall counter.
        repeat (65540) @(posedge clk);
        #1;
        chk("sat_stall", stall_cnt, 16'hFFFF);
        repeat (3) @(posedge clk);
        #1;
        chk("sat_stall_hold", stall_cnt, 16'hFFFF);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
